alpaca_round_sat: RTL and testbench
===================================

ALPACA_ROUND_SAT -- requirements
Module: alpaca_round_sat

Purpose: downstream stage of the multiply-add; narrows the wide phase_mac_t result to sample_t with convergent rounding, saturation and valid/ready flow control.

Interface
REQ-001 SHALL have parameter IN_W, default 35, input width (WIDTH+PHASE_WIDTH+1).
REQ-002 SHALL have parameter IN_F, default 32, input fraction bits (FRAC_WIDTH+PHASE_FRAC_WIDTH).
REQ-003 SHALL have parameter OUT_W, default 16, output width (WIDTH).
REQ-004 SHALL have parameter OUT_F, default 15, output fraction bits (FRAC_WIDTH).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port din_tdata  input  IN_W  signed two's-complement multiply-add result.
REQ-008 SHALL have port din_tvalid  input  1  din_tdata valid.
REQ-009 SHALL have port din_tready  output  1  stage accepts din this cycle.
REQ-010 SHALL have port dout_tdata  output  OUT_W  signed rounded/saturated sample.
REQ-011 SHALL have port dout_tvalid  output  1  dout_tdata valid.
REQ-012 SHALL have port dout_tready  input  1  consumer accepts dout.
REQ-013 SHALL have port ovf  output  1  sticky flag, set on any saturation.
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of ovf (and ovf_count).

Function
REQ-015 SHALL elaborate only if IN_F >= OUT_F+1 and (IN_W-IN_F) >= (OUT_W-OUT_F); otherwise fatal elaboration error.
REQ-016 SHALL treat the low D = IN_F-OUT_F bits as discarded; result = arithmetic shift right by D, rounded half-to-even.
REQ-017 SHALL round: add 1 when discarded bits > half-LSB, or == half-LSB and kept LSB = 1; rounding add done at IN_W-D+1 bits so no wrap.
REQ-018 SHALL saturate the rounded value to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; saturation event when rounded value lies outside that range.
REQ-019 SHALL be a two-stage pipeline: stage 1 registers rounded value, stage 2 registers saturated value and saturation bit.
REQ-020 SHALL define advance = !dout_tvalid || dout_tready; din_tready = advance (combinational); both stages load only when advance.
REQ-021 SHALL give latency of exactly 2 cycles from din handshake to dout_tvalid when dout_tready held high; throughput one sample per cycle.
REQ-022 SHALL hold dout_tdata/dout_tvalid stable while dout_tvalid=1 and dout_tready=0; no sample dropped or duplicated.
REQ-023 SHALL propagate valid bits with data; bubbles (din_tvalid=0) pass through as dout_tvalid=0.
REQ-024 SHALL set ovf in the cycle a saturated sample is transferred on dout (dout_tvalid && dout_tready).
REQ-025 SHALL give ovf_clr priority below a same-cycle saturation transfer: ovf ends at 1.

Reset
REQ-026 SHALL, on rst assertion, immediately clear both stage valids, dout_tdata=0, dout_tvalid=0, ovf=0 (and ovf_count=0), independent of clk.
REQ-027 SHALL discard in-flight samples on reset mid-stream; first output after release is the first sample accepted after release.
REQ-028 SHALL drive din_tready=1 during and immediately after reset.

Configuration
REQ-029 SHALL, with macro ALPACA_ROUND_SAT_OVF_COUNT_EN defined, add output ovf_count [15:0]: increments per transferred saturated sample, saturates at 65535, cleared by ovf_clr/rst.
REQ-030 SHALL, without ALPACA_ROUND_SAT_OVF_COUNT_EN, omit the ovf_count port and counter; all other behaviour identical.

Verification (defaults; din in units of 2^-32, dout LSB = 2^17 din units)
REQ-031 SHALL verify: din = 3*2^16, 2^16, 5*2^16, 7*2^16 with dout_tready=1 -> dout 2, 0, 2, 4 exactly 2 cycles later, ovf=0.
REQ-032 SHALL verify: din = 2^31 -> 16384; din = -2^32 -> -32768 with ovf=0; din = 2^32 -> 32767 with ovf=1.
REQ-033 SHALL verify: din = -2^32-2^17 -> -32768, ovf=1; ovf_clr pulse -> ovf=0 next cycle (ovf_count 0 if enabled).
REQ-034 SHALL verify: 100 random samples with random din_tvalid and dout_tready (50%) -> output sequence equals reference model in order, dout stable while stalled.
REQ-035 SHALL verify: rst asserted mid-stream with 2 samples in flight -> dout_tvalid=0 asynchronously, no stale sample emitted after release.
REQ-036 SHALL verify (macro defined): 3 saturating samples transferred -> ovf_count=3; simultaneous ovf_clr and saturating transfer -> ovf=1.

Source files
------------

// File: rtl/alpaca_round_sat.sv
//------------------------------------------------------------------------------
// alpaca_round_sat
//
// Purpose:
//   Output stage of the multiply-add. Narrows the wide signed result
//   (IN_W bits, IN_F fraction bits) to a signed sample (OUT_W bits,
//   OUT_F fraction bits). Rounding is round-half-to-even, followed by
//   saturation. Flow control is valid/ready.
//
//   Pipeline structure:
//     stage 1  registers the rounded value, one bit wider than the kept bits.
//     stage 2  registers the saturated sample and its saturation flag.
//
//   Both stages load only when the output is free or is being consumed.
//
// Optional feature:
//   Define ALPACA_ROUND_SAT_OVF_COUNT_EN to add the ovf_count output. It is a
//   16-bit count of transferred saturated samples that stops at 65535.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   din_tdata    in   IN_W  signed multiply-add result
//   din_tvalid   in   din_tdata valid
//   din_tready   out  stage accepts din this cycle
//   dout_tdata   out  OUT_W signed rounded/saturated sample
//   dout_tvalid  out  dout_tdata valid
//   dout_tready  in   consumer accepts dout
//   ovf          out  sticky saturation flag
//   ovf_clr      in   synchronous clear of ovf (and ovf_count)
//   ovf_count    out  [15:0] saturation event count (optional)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module alpaca_round_sat #(
  parameter int IN_W  = 35,
  parameter int IN_F  = 32,
  parameter int OUT_W = 16,
  parameter int OUT_F = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  din_tdata,
  input  logic                    din_tvalid,
  output logic                    din_tready,
  output logic signed [OUT_W-1:0] dout_tdata,
  output logic                    dout_tvalid,
  input  logic                    dout_tready,
  output logic                    ovf,
  input  logic                    ovf_clr
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
  ,
  output logic [15:0]             ovf_count
`endif
);

  // D low bits are discarded.
  // KW bits are kept.
  // RW is one bit wider than KW, so the +1 rounding step cannot wrap.
  localparam int D  = IN_F - OUT_F;
  localparam int KW = IN_W - D;
  localparam int RW = KW + 1;

  generate
    if (!((IN_F >= OUT_F + 1) && ((IN_W - IN_F) >= (OUT_W - OUT_F)))) begin : g_param_check
      $fatal(1, "alpaca_round_sat: unsupported IN_W/IN_F/OUT_W/OUT_F combination");
    end
  endgenerate

  localparam logic [D-1:0] HALF = D'(1) << (D - 1);

  // Output range limits, sign-extended to the rounded width for comparison.
  localparam logic signed [RW-1:0] MAX_R =
    {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R =
    {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // Pipeline registers.
  logic                    s1_valid_q;
  logic signed [RW-1:0]    s1_data_q;
  logic                    dout_valid_q;
  logic [OUT_W-1:0]        dout_data_q;
  logic                    sat_q;
  logic                    ovf_q;
  logic                    ovf_d;

  // Stage 1 combinational: convergent rounding.
  logic [KW-1:0]           kept;
  logic [D-1:0]            disc;
  logic                    round_up;
  logic signed [RW-1:0]    rounded_d;

  // Stage 2 combinational: saturation.
  logic [OUT_W-1:0]        sat_val_d;
  logic                    sat_d;

  logic                    advance;
  logic                    xfer_sat;

  assign advance    = !dout_valid_q || dout_tready;
  assign din_tready = advance;

  assign kept = din_tdata[IN_W-1:D];
  assign disc = din_tdata[D-1:0];

  // Exactly half an output LSB is a tie. A tie rounds toward the even kept value.
  assign round_up  = (disc > HALF) || ((disc == HALF) && kept[0]);
  assign rounded_d = {kept[KW-1], kept} + {{(RW - 1){1'b0}}, round_up};

  always_comb begin
    sat_val_d = s1_data_q[OUT_W-1:0];
    sat_d     = 1'b0;
    if (s1_data_q > MAX_R) begin
      sat_val_d = OUT_MAX;
      sat_d     = 1'b1;
    end else if (s1_data_q < MIN_R) begin
      sat_val_d = OUT_MIN;
      sat_d     = 1'b1;
    end
  end

  // Data registers load only alongside a valid sample.
  // During a bubble, the last sample stays on dout_tdata while dout_tvalid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      sat_q        <= 1'b0;
    end else if (advance) begin
      s1_valid_q   <= din_tvalid;
      dout_valid_q <= s1_valid_q;
      if (din_tvalid) begin
        s1_data_q <= rounded_d;
      end
      if (s1_valid_q) begin
        dout_data_q <= sat_val_d;
        sat_q       <= sat_d;
      end
    end
  end

  assign dout_tdata  = dout_data_q;
  assign dout_tvalid = dout_valid_q;

  // A saturated sample is counted only when the consumer actually takes it.
  assign xfer_sat = dout_valid_q && dout_tready && sat_q;

  // A saturation transfer outranks a same-cycle clear, so ovf ends up set.
  always_comb begin
    ovf_d = ovf_q;
    if (xfer_sat) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // A clear coinciding with a saturation transfer restarts the count at 1.
  // This keeps the count consistent with ovf.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = {15'd0, xfer_sat};
    end else if (xfer_sat && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`endif

endmodule

// File: tb/tb_alpaca_round_sat.sv
`timescale 1ns/1ps

module tb_alpaca_round_sat;

  localparam int IN_W  = 35;
  localparam int IN_F  = 32;
  localparam int OUT_W = 16;
  localparam int OUT_F = 15;
  localparam int D     = IN_F - OUT_F;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  din_tdata;
  logic                    din_tvalid;
  logic                    din_tready;
  logic signed [OUT_W-1:0] dout_tdata;
  logic                    dout_tvalid;
  logic                    dout_tready = 1'b1;
  logic                    ovf;
  logic                    ovf_clr;
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
  logic [15:0]             ovf_count;
`endif

  alpaca_round_sat #(
    .IN_W (IN_W),
    .IN_F (IN_F),
    .OUT_W(OUT_W),
    .OUT_F(OUT_F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_tdata  (din_tdata),
    .din_tvalid (din_tvalid),
    .din_tready (din_tready),
    .dout_tdata (dout_tdata),
    .dout_tvalid(dout_tvalid),
    .dout_tready(dout_tready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     sat;
    bit     lat_chk;
    int     cyc_in;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     lat_mode = 1'b0;
  int     ready_mode = 0;   // 0: ready high, 1: ready low, 2: random

  always @(posedge clk) cyc++;

  // Reference model in plain arithmetic.
  // Take the floor of v / 2^D, then round ties to even, then clamp.
  function automatic exp_t model(input longint v);
    exp_t   e;
    longint unit;
    longint half;
    longint q;
    longint r;
    longint hi;
    longint lo;
    unit = longint'(1) << D;
    half = unit / 2;
    hi   = (longint'(1) << (OUT_W - 1)) - 1;
    lo   = -(longint'(1) << (OUT_W - 1));
    q = v / unit;
    if ((v % unit) < 0) q = q - 1;
    r = v - q * unit;
    if ((r > half) || ((r == half) && (q % 2 != 0))) q = q + 1;
    e.sat = 1'b0;
    if (q > hi) begin
      q = hi;
      e.sat = 1'b1;
    end else if (q < lo) begin
      q = lo;
      e.sat = 1'b1;
    end
    e.data    = q;
    e.lat_chk = 1'b0;
    e.cyc_in  = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Input-side scoreboard feed: every accepted sample pushes its expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else if (din_tvalid && din_tready) begin
      e = model(longint'(din_tdata));
      e.lat_chk = lat_mode;
      e.cyc_in  = cyc;
      sb.push_back(e);
    end
  end

  // Output monitor: compares transfers, hold-while-stalled, and the ovf model.
  bit                    m_ovf = 1'b0;
  int                    m_cnt = 0;
  bit                    stall_q = 1'b0;
  logic signed [OUT_W-1:0] held;

  always @(negedge clk) begin
    exp_t e;
    bit   xs;
    xs = 1'b0;
    if (rst) begin
      m_ovf   = 1'b0;
      m_cnt   = 0;
      stall_q = 1'b0;
    end else begin
      check("ovf", longint'(ovf), longint'(m_ovf));
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
      check("ovf_count", longint'(ovf_count), longint'(m_cnt));
`endif
      if (stall_q) begin
        check("stall_valid", longint'(dout_tvalid), 1);
        check("stall_data", longint'(dout_tdata), longint'(held));
      end
      if (dout_tvalid && dout_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no sample", dout_tdata);
        end else begin
          e = sb.pop_front();
          check("dout_tdata", longint'(dout_tdata), e.data);
          if (e.lat_chk) check("latency", longint'(cyc - e.cyc_in), 2);
          xs = e.sat;
          $display("xfer cyc=%0d dout=%0d exp=%0d sat=%0d", cyc, dout_tdata, e.data, e.sat);
        end
      end
      stall_q = dout_tvalid && !dout_tready;
      held    = dout_tdata;
      if (xs) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (ovf_clr) m_cnt = int'(xs);
      else if (xs && (m_cnt < 65535)) m_cnt++;
    end
  end

  // Sole driver of dout_tready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_tready = 1'b1;
      1:       dout_tready = 1'b0;
      default: dout_tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input longint v);
    bit ok;
    int n;
    din_tdata  = v[IN_W-1:0];
    din_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = din_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && (n < 500));
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got din_tready=0 expected 1 within 500 cycles");
    end
    din_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 300)) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, longint'(sb.size()), 0);
  endtask

  function automatic longint rand_val();
    longint v;
    case ($urandom_range(0, 2))
      0: begin
        v = longint'({$urandom, $urandom});
        v = (v << (64 - IN_W)) >>> (64 - IN_W);
      end
      1: v = longint'(int'($urandom)) * 2;
      default: v = (longint'($urandom_range(0, 131071)) - 65536) * 131072 + 65536;
    endcase
    return v;
  endfunction

  initial begin
    rst        = 1'b1;
    din_tvalid = 1'b0;
    din_tdata  = '0;
    ovf_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_tvalid", longint'(dout_tvalid), 0);
    check("rst_dout_tdata", longint'(dout_tdata), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_din_tready", longint'(din_tready), 1);
    rst = 1'b0;
    #1;
    check("post_rst_din_tready", longint'(din_tready), 1);
    idle(1);

    // Tie rounding with back-to-back samples and a 2-cycle latency check.
    lat_mode = 1'b1;
    send(longint'(3) << 16);
    send(longint'(1) << 16);
    send(longint'(5) << 16);
    send(longint'(7) << 16);
    send(longint'(1) << 31);
    send(-(longint'(1) << 32));
    idle(4);
    check("ovf_after_inrange", longint'(ovf), 0);

    send(longint'(1) << 32);
    idle(4);
    check("ovf_after_pos_sat", longint'(ovf), 1);
    pulse_clr();
    check("ovf_cleared", longint'(ovf), 0);

    send(-(longint'(1) << 32) - (longint'(1) << 17));
    idle(4);
    check("ovf_after_neg_sat", longint'(ovf), 1);
    pulse_clr();
    check("ovf_cleared2", longint'(ovf), 0);
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
    check("ovf_count_cleared", longint'(ovf_count), 0);
`endif

    send(longint'(1) << 33);
    send(-(longint'(1) << 33));
    send((longint'(1) << 34) - 1);
    idle(4);
`ifdef ALPACA_ROUND_SAT_OVF_COUNT_EN
    check("ovf_count_three", longint'(ovf_count), 3);
`endif
    pulse_clr();

    // Assert the clear in the exact cycle a saturated sample transfers.
    send(longint'(1) << 33);
    idle(1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr_vs_sat", longint'(ovf), 1);
    lat_mode = 1'b0;
    idle(2);

    // Random traffic with random bubbles and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send(rand_val());
    end
    ready_mode = 0;
    drain("drain_random");

    // Reset with two samples in flight while the output is stalled.
    ready_mode = 1;
    idle(2);
    send(longint'(3) << 16);
    send(longint'(5) << 16);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dout_tvalid", longint'(dout_tvalid), 0);
    check("async_rst_dout_tdata", longint'(dout_tdata), 0);
    check("async_rst_din_tready", longint'(din_tready), 1);
    check("async_rst_ovf", longint'(ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    idle(2);
    check("post_rst_no_stale", longint'(dout_tvalid), 0);
    send(longint'(7) << 16);
    drain("drain_after_rst");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
